// File: rtl/mp_add_sequencer_if.sv
// Start/done handshake and operand/result bus for the
// multi-precision add sequencer.
interface mp_add_sequencer_if #(
  parameter int N     = 16,
  parameter int WORDS = 4
);
  logic               start;
  logic [N*WORDS-1:0] op_a;
  logic [N*WORDS-1:0] op_b;
  logic               cin;
  logic               busy;
  logic               done;
  logic [N*WORDS-1:0] result;
  logic               cout;
  logic               overflow;

  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/mp_add_sequencer.sv
// Word-serial wide adder: drives one ripple-carry stage LSW first,
// chaining each word's carry-out into the next word's carry-in.
module RippleCarryAdder #(
  parameter int N = 16
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);
  logic [N:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[N];
endmodule

module mp_add_sequencer #(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input logic                clk,
  input logic                rst_n,
  mp_add_sequencer_if.slave  bus
);
  localparam int W  = N * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  res_q;
  logic          cout_q;
  logic          ovf_q;

  logic [N-1:0]  wa;
  logic [N-1:0]  wb;
  logic [N-1:0]  s;
  logic          co;

  assign wa = a_q[idx*N +: N];
  assign wb = b_q[idx*N +: N];

  RippleCarryAdder #(.N(N)) u_rca (
    .A    (wa),
    .B    (wb),
    .Cin  (carry),
    .S    (s),
    .Cout (co)
  );

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.result   = res_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

  // Sequencer: accept in IDLE, one word per cycle in ADD, pulse in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= ADD;
            a_q    <= bus.op_a;
            b_q    <= bus.op_b;
            carry  <= bus.cin;
            idx    <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
        end
        ADD: begin
          res_q[idx*N +: N] <= s;
          carry             <= co;
          if (idx == LAST) begin
            state  <= DONE;
            cout_q <= co;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) &&
                      (s[N-1] != a_q[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer (N=16, WORDS=4).
// Expected sums come from a behavioural wide add.
module tb_mp_add_sequencer;
  localparam int N     = 16;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   n_done;
  exp_t q[$];

  mp_add_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

  mp_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic c);
    exp_t e;
    logic [W:0] sum;
    sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.res = sum[W-1:0];
    e.co  = sum[W];
    e.ov  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse is matched against the oldest request.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      n_done++;
      chk("busy_in_done", bus.busy, 1);
      if (q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("result", bus.result, e.res);
        chk("cout", bus.cout, e.co);
        chk("overflow", bus.overflow, e.ov);
      end
    end
  end

  task automatic drive_start(input logic [W-1:0] a,
                             input logic [W-1:0] b,
                             input logic c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = '1;
    bus.op_b  = '1;
    bus.cin   = 1'b1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 30);
    if (!bus.done) chk("timeout", 0, 1);
  endtask

  task automatic add_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic c);
    exp_t e;
    int   lat;
    e = model(a, b, c);
    q.push_back(e);
    drive_start(a, b, c);
    wait_done(lat);
    chk("latency", lat, WORDS + 1);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    repeat (2) @(negedge clk);
    chk("hold_result", bus.result, e.res);
    chk("hold_busy", bus.busy, 0);
  endtask

  initial begin
    int lat;
    int d0;
    n_cmp     = 0;
    n_bad     = 0;
    n_done    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.op_a  = 64'h1234;
    bus.op_b  = 64'h5678;
    bus.cin   = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.overflow, 0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done_cnt", n_done, 0);

    add_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    add_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    add_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    add_op(64'h8000_0000_0000_0000,
           64'h8000_0000_0000_0000, 1'b0);
    add_op(64'h0123_4567_89AB_CDEF,
           64'hFEDC_BA98_7654_3210, 1'b1);

    for (int i = 0; i < 3; i++) begin
      add_op({$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)));
    end

    // Start while busy is ignored.
    d0 = n_done;
    q.push_back(model(64'h1234, 64'h1, 1'b0));
    drive_start(64'h1234, 64'h1, 1'b0);
    @(negedge clk);
    drive_start('1, '1, 1'b0);
    wait_done(lat);
    repeat (12) @(negedge clk);
    chk("busy_ignore_dones", n_done - d0, 1);
    chk("busy_ignore_result", bus.result, 64'h1235);

    // Reset during word 2 abandons the add.
    d0 = n_done;
    drive_start(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_cout", bus.cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_done", n_done - d0, 0);
    add_op(64'h2, 64'h3, 1'b1);
    chk("after_rst_result", bus.result, 64'h6);

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
- Multi-precision add controller that drives a `RippleCarryAdder` instance with N-bit operand words, one word per cycle, least-significant word first.
- Each word's `Cout` is registered and fed back as the next word's `Cin`, forming a WORDS*N-bit sum.
- Sits directly upstream of the adder, supplying its A/B/Cin, and directly downstream of it, capturing S/Cout.
- Gives the datapath a wide add built from the existing 16-bit ripple-carry stage, using a start/done handshake.

Parameters:
- N, 16, adder word width; passed to the internal `RippleCarryAdder`.
- WORDS, 4, number of N-bit words per operand; must be >= 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  N*WORDS  operand A; word k is bits [k*N +: N].
- op_b  input  N*WORDS  operand B; same layout as op_a.
- cin  input  1  carry-in for word 0.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  N*WORDS  registered sum; held until the next accepted start.
- cout  output  1  carry out of the most significant word.
- overflow  output  1  signed overflow of the full-width add.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, word index=0, carry register=0.
  - Latched operands cleared.
  - busy=0, done=0, result=0, cout=0, overflow=0.
  - Takes effect immediately, including mid-operation; the in-flight add is abandoned with no done pulse.
- FSM states: IDLE, ADD, DONE.
- IDLE -> ADD when start=1 at a clock edge. On that edge:
  - latch op_a, op_b;
  - carry register <= cin;
  - index <= 0;
  - clear result, cout and overflow to 0.
- ADD, each cycle:
  - adder A = latched a word[index], B = latched b word[index], Cin = carry register.
  - At the edge: result word[index] <= S; carry register <= Cout; index <= index+1.
- ADD -> DONE on the edge that writes word WORDS-1. On that same edge:
  - cout <= Cout;
  - overflow <= (a_msb == b_msb) && (S_msb != a_msb), using bit N-1 of the top word.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE unconditionally.
- Latency: start sampled at edge t -> done high in the cycle after edge t+WORDS, i.e. WORDS+1 cycles after acceptance.
- Back-to-back: earliest next acceptance is the edge at which DONE returns to IDLE, plus one (start must be seen in IDLE).
- start while busy=1 (ADD or DONE): ignored, no queuing; operands latched at acceptance are unaffected.
- op_a/op_b/cin may change freely after acceptance.
- Widths: all sums modulo 2^(N*WORDS). The index counter must hold 0..WORDS-1 and never wraps within an operation.
- result, cout and overflow are stable from done until the next accepted start.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan (N=16, WORDS=4):
- Reset: hold rst_n=0 with start=1 -> busy=0, done=0, result=0, cout=0, overflow=0; release, start idle -> no activity.
- Carry chain across word boundary: op_a=0x0000_0000_0000_FFFF, op_b=0x1, cin=0 -> result=0x0000_0000_0001_0000, cout=0, overflow=0; done exactly 5 cycles after the start edge.
- Full ripple with cin: op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0, cin=1 -> result=0, cout=1, overflow=0.
- Signed overflow: op_a=0x7FFF_FFFF_FFFF_FFFF, op_b=0x1, cin=0 -> result=0x8000_0000_0000_0000, cout=0, overflow=1; and op_a=op_b=0x8000_0000_0000_0000 -> result=0, cout=1, overflow=1.
- Start while busy: start with a=0x1234, b=0x1; two cycles later pulse start with a=0xFFFF…, b=0xFFFF… -> second request ignored; result=0x1235, a single done pulse.
- Reset mid-operation: assert rst_n=0 during word 2 of an add -> outputs cleared asynchronously, no done pulse; after release a new start (a=2, b=3, cin=1) -> result=6 with normal latency.
